fxy_sweep_ctrl: RTL and testbench

FXY_SWEEP_CTRL -- requirements
Module: fxy_sweep_ctrl

---
 rtl/fxy_pkg.sv | 15 +
 rtl/fxy_sweep_ctrl_if.sv | 29 ++
 rtl/fxy_settle_timer.sv | 42 ++++
 rtl/fxy_sweep_ctrl.sv | 125 ++++++++++++
 tb/tb_fxy_sweep_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/fxy_pkg.sv
// Shared types and sizing for the fxy truth-table sweep controller.
package fxy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int N_VEC      = 4;
  localparam int RESULT_W   = 8;
  localparam int MAX_SETTLE = 15;
  localparam int SETTLE_W   = $clog2(MAX_SETTLE + 1);

endpackage

// File: rtl/fxy_sweep_ctrl_if.sv
// Handshake and data bundle between the sweep controller and its environment.
// The environment (bench or top level) owns start/expected and the evaluator
// outputs s1/s2; the controller owns everything else.
interface fxy_sweep_ctrl_if;
  import fxy_pkg::*;

  logic                start;
  logic [RESULT_W-1:0] expected;
  logic                x;
  logic                y;
  logic                s1;
  logic                s2;
  logic                busy;
  logic                done;
  logic                pass;
  logic [RESULT_W-1:0] result;
  logic [N_VEC-1:0]    mismatch;

  modport master (
    output start, expected, s1, s2,
    input  x, y, busy, done, pass, result, mismatch
  );

  modport slave (
    input  start, expected, s1, s2,
    output x, y, busy, done, pass, result, mismatch
  );

endinterface

// File: rtl/fxy_settle_timer.sv
// Settle counter: counts cycles while enabled, wraps to zero on terminal count.
// tc is only asserted while enabled so the caller can use it as a capture strobe.
module fxy_settle_timer
  import fxy_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  assign tc = enable && (cnt_q == SETTLE_W'(SETTLE_CYCLES - 1));

  // Next count: clear wins, otherwise count up and wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (tc) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fxy_sweep_ctrl.sv
// Truth-table sweep controller: drives x/y through 00,01,10,11, holds each
// vector for SETTLE_CYCLES cycles, captures {s1,s2} at the end of each hold
// and compares against a snapshot of the golden table taken at start.
module fxy_sweep_ctrl
  import fxy_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  fxy_sweep_ctrl_if.slave  bus
);

  localparam int K_W = $clog2(N_VEC);

  state_e              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [RESULT_W-1:0] snap_q, snap_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic [N_VEC-1:0]    mismatch_q, mismatch_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;

  logic                settle_clear;
  logic                settle_en;
  logic                settle_tc;
  logic [1:0]          pair;

  // The timer only runs in DRIVE; holding it clear elsewhere guarantees every
  // sweep starts from a zero settle count.
  assign settle_clear = (state_q != DRIVE);
  assign settle_en    = (state_q == DRIVE);
  assign pair         = {bus.s1, bus.s2};

  fxy_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .reset  (reset),
    .clear  (settle_clear),
    .enable (settle_en),
    .tc     (settle_tc)
  );

  // Next-state and output computation for the three-state sweep FSM.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    snap_d     = snap_q;
    result_d   = result_q;
    mismatch_d = mismatch_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap_d     = bus.expected;
          result_d   = '0;
          mismatch_d = '0;
          pass_d     = 1'b0;
          k_d        = '0;
          busy_d     = 1'b1;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_tc) begin
          result_d[{k_q, 1'b0} +: 2] = pair;
          mismatch_d[k_q] = (pair != snap_q[{k_q, 1'b0} +: 2]);
          if (k_q == K_W'(N_VEC - 1)) begin
            state_d = FINISH;
            done_d  = 1'b1;
            pass_d  = (mismatch_d == '0);
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        k_d     = '0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        k_d     = '0;
      end
    endcase
  end

  // State and registered outputs, all cleared by asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      snap_q     <= '0;
      result_q   <= '0;
      mismatch_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      snap_q     <= snap_d;
      result_q   <= result_d;
      mismatch_q <= mismatch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign bus.x        = k_q[1];
  assign bus.y        = k_q[0];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.result   = result_q;
  assign bus.mismatch = mismatch_q;

endmodule

// File: tb/tb_fxy_sweep_ctrl.sv
// Bench for fxy_sweep_ctrl: two controllers (settle 1 and settle 3) each driving
// a table-driven fxy evaluator; a selector routes start and observation.
module tb_fxy_sweep_ctrl;
  import fxy_pkg::*;

  localparam logic [7:0] NOR_TABLE = 8'h03;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] expected;
  logic [7:0] evalTable;
  logic       sel;

  int testsRun    = 0;
  int testsFailed = 0;

  fxy_sweep_ctrl_if bus1 ();
  fxy_sweep_ctrl_if bus3 ();

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  assign bus1.start    = start & ~sel;
  assign bus3.start    = start & sel;
  assign bus1.expected = expected;
  assign bus3.expected = expected;

  // Evaluator model: pair for vector k={x,y} is evalTable[2k+1:2k] = {s1,s2}.
  assign bus1.s1 = evalTable[{bus1.x, bus1.y, 1'b1}];
  assign bus1.s2 = evalTable[{bus1.x, bus1.y, 1'b0}];
  assign bus3.s1 = evalTable[{bus3.x, bus3.y, 1'b1}];
  assign bus3.s2 = evalTable[{bus3.x, bus3.y, 1'b0}];

  logic       obsX, obsY, obsBusy, obsDone, obsPass;
  logic [7:0] obsResult;
  logic [3:0] obsMismatch;

  assign obsX        = sel ? bus3.x        : bus1.x;
  assign obsY        = sel ? bus3.y        : bus1.y;
  assign obsBusy     = sel ? bus3.busy     : bus1.busy;
  assign obsDone     = sel ? bus3.done     : bus1.done;
  assign obsPass     = sel ? bus3.pass     : bus1.pass;
  assign obsResult   = sel ? bus3.result   : bus1.result;
  assign obsMismatch = sel ? bus3.mismatch : bus1.mismatch;

  fxy_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  fxy_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] required);
    testsRun++;
    assert (observed === required)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, required);
    end
  endtask

  // Reference: per-vector pair comparison between evaluator table and golden table.
  function automatic logic [3:0] refMismatch(input logic [7:0] tbl, input logic [7:0] gold);
    logic [3:0] m;
    for (int v = 0; v < 4; v++) begin
      m[v] = (tbl[2*v +: 2] != gold[2*v +: 2]);
    end
    return m;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_xy"}, {obsX, obsY}, 0);
    checkOutput({tag, "_busy"}, obsBusy, 0);
    checkOutput({tag, "_done"}, obsDone, 0);
    checkOutput({tag, "_pass"}, obsPass, 0);
    checkOutput({tag, "_result"}, obsResult, 0);
    checkOutput({tag, "_mismatch"}, obsMismatch, 0);
  endtask

  // One full sweep on the selected controller, checked cycle by cycle.
  task automatic applyStimulus(input int settle, input logic [7:0] tbl,
                               input logic [7:0] gold, input bit repulse,
                               input bit scramble);
    logic [3:0] mExp;
    logic [7:0] partial;
    int         vec;
    sel       = (settle == 3);
    evalTable = tbl;
    expected  = gold;
    mExp      = refMismatch(tbl, gold);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 4 * settle; c++) begin
      vec = c / settle;
      partial = 8'h00;
      for (int v = 0; v < vec; v++) partial[2*v +: 2] = tbl[2*v +: 2];
      checkOutput("sweep_xy", {obsX, obsY}, vec[1:0]);
      checkOutput("sweep_busy", obsBusy, 1);
      checkOutput("sweep_done", obsDone, 0);
      checkOutput("sweep_pass", obsPass, 0);
      checkOutput("sweep_partial", obsResult, partial);
      if (repulse) start = (c == 2 * settle);
      if (scramble) expected = 8'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput("fin_done", obsDone, 1);
    checkOutput("fin_busy", obsBusy, 1);
    checkOutput("fin_xy", {obsX, obsY}, 3);
    checkOutput("fin_result", obsResult, tbl);
    checkOutput("fin_mismatch", obsMismatch, mExp);
    checkOutput("fin_pass", obsPass, (mExp == 4'h0));
    @(posedge clk); #1;
    checkOutput("idle_done", obsDone, 0);
    checkOutput("idle_busy", obsBusy, 0);
    checkOutput("idle_xy", {obsX, obsY}, 0);
    expected = ~gold;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_done", obsDone, 0);
    checkOutput("hold_busy", obsBusy, 0);
    checkOutput("hold_result", obsResult, tbl);
    checkOutput("hold_mismatch", obsMismatch, mExp);
    checkOutput("hold_pass", obsPass, (mExp == 4'h0));
  endtask

  initial begin
    int         doneIdx[$];
    int         expCount;
    int         guard;
    int         settle;
    logic [7:0] tbl;
    logic [7:0] gold;

    start     = 1'b0;
    expected  = 8'h00;
    evalTable = NOR_TABLE;
    sel       = 1'b0;
    reset     = 1'b1;

    // Reset state on both controllers before any clock edge.
    #3;
    checkAllZero("reset1");
    sel = 1'b1;
    #0;
    checkAllZero("reset3");
    sel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Matching NOR table, then a golden table that disagrees on vector 1.
    applyStimulus(1, NOR_TABLE, 8'h03, 1'b0, 1'b0);
    applyStimulus(1, NOR_TABLE, 8'h0F, 1'b0, 1'b0);

    // start re-pulsed during vector 2 must be ignored.
    applyStimulus(1, NOR_TABLE, 8'h03, 1'b1, 1'b0);

    // Settle of three cycles per vector.
    applyStimulus(3, NOR_TABLE, 8'h03, 1'b0, 1'b0);

    // Reset asserted mid-cycle during vector 2 aborts the sweep.
    sel = 1'b0;
    evalTable = NOR_TABLE;
    expected = 8'h03;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort_pre_xy", {obsX, obsY}, 2);
    checkOutput("abort_pre_result", obsResult, 8'h03);
    #1;
    reset = 1'b1;
    #1;
    checkAllZero("abort");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("abort_nodone", obsDone, 0);
    end
    applyStimulus(1, NOR_TABLE, 8'h03, 1'b0, 1'b0);

    // Randomized sweeps with golden tables that sometimes match.
    for (int r = 0; r < 12; r++) begin
      settle = ($urandom_range(0, 1) == 1) ? 3 : 1;
      tbl    = 8'($urandom);
      gold   = ($urandom_range(0, 2) == 0) ? tbl : 8'($urandom);
      applyStimulus(settle, tbl, gold, 1'b0, bit'($urandom_range(0, 1)));
    end

    // start held high: back-to-back sweeps with a single idle cycle between.
    settle = 1;
    sel = 1'b0;
    evalTable = NOR_TABLE;
    expected = 8'h03;
    start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (obsDone) doneIdx.push_back(i);
    end
    start = 1'b0;
    expCount = 0;
    for (int i = 0; i < 24; i++) begin
      if (i >= 4 * settle && ((i - 4 * settle) % (4 * settle + 2)) == 0) expCount++;
    end
    checkOutput("b2b_count", doneIdx.size(), expCount);
    checkOutput("b2b_first", (doneIdx.size() > 0) ? doneIdx[0] : -1, 4 * settle);
    for (int j = 1; j < doneIdx.size(); j++) begin
      checkOutput("b2b_period", doneIdx[j] - doneIdx[j-1], 4 * settle + 2);
    end
    guard = 0;
    while (obsBusy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("b2b_drain", obsBusy, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
